// File: rtl/dionysus_sdram_init_seq_pkg.sv
// Shared definitions for the Dionysus SDRAM init sequencer: sequencer states,
// SDRAM command encodings {cs_n, ras_n, cas_n, we_n} and the default mode word.
package dionysus_sdram_init_seq_pkg;

    typedef enum logic [3:0] {
        ST_WAIT_LOCK,
        ST_POWERUP,
        ST_PRECHARGE,
        ST_WAIT_TRP,
        ST_REFRESH,
        ST_WAIT_TRFC,
        ST_LOAD_MODE,
        ST_WAIT_TMRD,
        ST_DONE
    } initState_e;

    localparam logic [3:0] CMD_DESELECT  = 4'b1111;
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] CMD_LMR       = 4'b0000;

    // Burst 8, sequential, CAS latency 3.
    localparam logic [11:0] MODE_REG_DEFAULT = 12'h033;
    localparam logic [11:0] ADDR_PRECHARGE_ALL = 12'h400;

    function automatic logic [3:0] stateCmd(input initState_e st);
        case (st)
            ST_WAIT_LOCK: return CMD_DESELECT;
            ST_PRECHARGE: return CMD_PRECHARGE;
            ST_REFRESH:   return CMD_REFRESH;
            ST_LOAD_MODE: return CMD_LMR;
            default:      return CMD_NOP;
        endcase
    endfunction

endpackage

// File: rtl/dionysus_sdram_lock_sync.sv
// Two-flop synchroniser for the PLL lock flag plus a run-length filter that
// flags the cycle on which lock has been seen high LOCK_STABLE times in a row.
module dionysus_sdram_lock_sync #(
    parameter int LOCK_STABLE = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pll_locked_i,
    output logic lock_s_o,
    output logic lock_stable_o
);

    localparam int RUN_W = $clog2(LOCK_STABLE + 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [RUN_W-1:0] runCnt_q;
    logic [RUN_W-1:0] runCnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            runCnt_q <= '0;
        end else begin
            sync1_q  <= pll_locked_i;
            sync2_q  <= sync1_q;
            runCnt_q <= runCnt_d;
        end
    end

    // The run counter saturates so a long lock never wraps back below threshold.
    always_comb begin
        runCnt_d = runCnt_q;
        if (!sync2_q) begin
            runCnt_d = '0;
        end else if (runCnt_q != RUN_W'(LOCK_STABLE)) begin
            runCnt_d = runCnt_q + 1'b1;
        end
    end

    assign lock_s_o      = sync2_q;
    assign lock_stable_o = sync2_q && (runCnt_q >= RUN_W'(LOCK_STABLE - 1));

endmodule

// File: rtl/dionysus_sdram_init_seq.sv
// JEDEC power-up sequencer: waits for stable PLL lock, then issues PRECHARGE ALL,
// REFRESH_COUNT auto refreshes and LOAD MODE before raising init_done_o.
module dionysus_sdram_init_seq
    import dionysus_sdram_init_seq_pkg::*;
#(
    parameter int          CLK_FREQ_MHZ  = 100,
    parameter int          POWERUP_US    = 200,
    parameter int          LOCK_STABLE   = 16,
    parameter int          TRP_CYCLES    = 2,
    parameter int          TRFC_CYCLES   = 7,
    parameter int          TMRD_CYCLES   = 2,
    parameter int          REFRESH_COUNT = 2,
    parameter logic [11:0] MODE_REG      = MODE_REG_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pll_locked_i,
    output logic        cke_o,
    output logic        cs_n_o,
    output logic        ras_n_o,
    output logic        cas_n_o,
    output logic        we_n_o,
    output logic [1:0]  ba_o,
    output logic [11:0] addr_o,
    output logic        init_done_o
);

    localparam int POWERUP_CYCLES = CLK_FREQ_MHZ * POWERUP_US;
    localparam int WAIT_W         = $clog2(POWERUP_CYCLES + 1);
    localparam int REF_W          = $clog2(REFRESH_COUNT + 1);

    initState_e        state_q, state_d;
    logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
    logic [REF_W-1:0]  refCnt_q, refCnt_d;
    logic              cke_q, cke_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [11:0]       addr_q, addr_d;
    logic              initDone_q, initDone_d;
    logic              lockS;
    logic              lockStable;

    dionysus_sdram_lock_sync #(
        .LOCK_STABLE (LOCK_STABLE)
    ) u_lock_sync (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .pll_locked_i  (pll_locked_i),
        .lock_s_o      (lockS),
        .lock_stable_o (lockStable)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_WAIT_LOCK;
            waitCnt_q  <= '0;
            refCnt_q   <= '0;
            cke_q      <= 1'b0;
            cmd_q      <= CMD_DESELECT;
            addr_q     <= '0;
            initDone_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            refCnt_q   <= refCnt_d;
            cke_q      <= cke_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            initDone_q <= initDone_d;
        end
    end

    // Wait states are loaded with (Txx-1)-1 so the next command lands exactly Txx
    // cycles after the previous one; the Txx timing parameters must be at least 2.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        refCnt_d  = refCnt_q;

        case (state_q)
            ST_WAIT_LOCK: begin
                waitCnt_d = '0;
                refCnt_d  = '0;
                if (lockStable) begin
                    state_d   = ST_POWERUP;
                    waitCnt_d = WAIT_W'(POWERUP_CYCLES - 1);
                end
            end
            ST_POWERUP, ST_WAIT_TRP, ST_WAIT_TRFC, ST_WAIT_TMRD: begin
                if (waitCnt_q != '0) begin
                    waitCnt_d = waitCnt_q - 1'b1;
                end else begin
                    case (state_q)
                        ST_POWERUP:   state_d = ST_PRECHARGE;
                        ST_WAIT_TRP:  state_d = ST_REFRESH;
                        ST_WAIT_TRFC: state_d = (refCnt_q < REF_W'(REFRESH_COUNT)) ?
                                                ST_REFRESH : ST_LOAD_MODE;
                        default:      state_d = ST_DONE;
                    endcase
                end
            end
            ST_PRECHARGE: begin
                state_d   = ST_WAIT_TRP;
                waitCnt_d = WAIT_W'(TRP_CYCLES - 2);
            end
            ST_REFRESH: begin
                state_d   = ST_WAIT_TRFC;
                waitCnt_d = WAIT_W'(TRFC_CYCLES - 2);
                refCnt_d  = refCnt_q + 1'b1;
            end
            ST_LOAD_MODE: begin
                state_d   = ST_WAIT_TMRD;
                waitCnt_d = WAIT_W'(TMRD_CYCLES - 2);
            end
            default: state_d = ST_DONE;
        endcase

        // Losing lock anywhere past WAIT_LOCK overrides any other transition.
        if (state_q != ST_WAIT_LOCK && !lockS) begin
            state_d   = ST_WAIT_LOCK;
            waitCnt_d = '0;
            refCnt_d  = '0;
        end
    end

    // Outputs are a function of the state being entered, so each command is
    // visible for exactly the one cycle its state is occupied.
    always_comb begin
        cke_d      = (state_d != ST_WAIT_LOCK);
        initDone_d = (state_d == ST_DONE);
        cmd_d      = stateCmd(state_d);
        addr_d     = '0;
        if (state_d == ST_PRECHARGE) begin
            addr_d = ADDR_PRECHARGE_ALL;
        end else if (state_d == ST_LOAD_MODE) begin
            addr_d = MODE_REG;
        end
    end

    assign cke_o       = cke_q;
    assign cs_n_o      = cmd_q[3];
    assign ras_n_o     = cmd_q[2];
    assign cas_n_o     = cmd_q[1];
    assign we_n_o      = cmd_q[0];
    assign ba_o        = 2'b00;
    assign addr_o      = addr_q;
    assign init_done_o = initDone_q;

endmodule

// File: tb/tb_dionysus_sdram_init_seq.sv
// Bench for the SDRAM init sequencer: two instances (2 and 8 refreshes) checked
// every cycle against a schedule model derived from the command timing rules.
module tb_dionysus_sdram_init_seq;

    localparam int LS   = 4;
    localparam int PU   = 100;
    localparam int TRP  = 2;
    localparam int TRFC = 7;
    localparam int TMRD = 2;
    localparam logic [19:0] RESET_VEC = 20'h78000;

    logic clk;
    logic rstN;
    logic pllLocked;

    logic        cke2, csN2, rasN2, casN2, weN2, done2;
    logic [1:0]  ba2;
    logic [11:0] addr2;
    logic        cke8, csN8, rasN8, casN8, weN8, done8;
    logic [1:0]  ba8;
    logic [11:0] addr8;
    logic [19:0] obs2, obs8;

    int total = 0;
    int bad   = 0;

    logic mS1, mS2, mActive;
    int   mRun, mT;

    dionysus_sdram_init_seq #(
        .CLK_FREQ_MHZ(100), .POWERUP_US(1), .LOCK_STABLE(LS), .TRP_CYCLES(TRP),
        .TRFC_CYCLES(TRFC), .TMRD_CYCLES(TMRD), .REFRESH_COUNT(2), .MODE_REG(12'h033)
    ) dut2 (
        .clk_i(clk), .rst_ni(rstN), .pll_locked_i(pllLocked), .cke_o(cke2),
        .cs_n_o(csN2), .ras_n_o(rasN2), .cas_n_o(casN2), .we_n_o(weN2),
        .ba_o(ba2), .addr_o(addr2), .init_done_o(done2)
    );

    dionysus_sdram_init_seq #(
        .CLK_FREQ_MHZ(100), .POWERUP_US(1), .LOCK_STABLE(LS), .TRP_CYCLES(TRP),
        .TRFC_CYCLES(TRFC), .TMRD_CYCLES(TMRD), .REFRESH_COUNT(8), .MODE_REG(12'h033)
    ) dut8 (
        .clk_i(clk), .rst_ni(rstN), .pll_locked_i(pllLocked), .cke_o(cke8),
        .cs_n_o(csN8), .ras_n_o(rasN8), .cas_n_o(casN8), .we_n_o(weN8),
        .ba_o(ba8), .addr_o(addr8), .init_done_o(done8)
    );

    assign obs2 = {cke2, csN2, rasN2, casN2, weN2, ba2, addr2, done2};
    assign obs8 = {cke8, csN8, rasN8, casN8, weN8, ba8, addr8, done8};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: lock seen through two delay stages, sequencing starts on the
    // LS-th consecutive high sample, mT counts cycles since cke rose.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mS1 <= 1'b0; mS2 <= 1'b0; mRun <= 0; mActive <= 1'b0; mT <= 0;
        end else begin
            mActive <= mActive ? mS2 : (mS2 && (mRun + 1 >= LS));
            mT      <= mActive ? mT + 1 : 0;
            mRun    <= mS2 ? mRun + 1 : 0;
            mS2     <= mS1;
            mS1     <= pllLocked;
        end
    end

    function automatic logic [19:0] expOut(input int rc);
        logic [3:0]  cmd;
        logic [11:0] a;
        logic        dn;
        if (!mActive) return RESET_VEC;
        cmd = 4'b0111;
        a   = 12'h000;
        dn  = 1'b0;
        if (mT == PU) begin
            cmd = 4'b0010;
            a   = 12'h400;
        end
        for (int k = 0; k < rc; k++) begin
            if (mT == PU + TRP + TRFC * k) cmd = 4'b0001;
        end
        if (mT == PU + TRP + TRFC * rc) begin
            cmd = 4'b0000;
            a   = 12'h033;
        end
        if (mT >= PU + TRP + TRFC * rc + TMRD) dn = 1'b1;
        return {1'b1, cmd, 2'b00, a, dn};
    endfunction

    task automatic checkVec(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
        end
    endtask

    task automatic checkInt(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkVec("dut2_outputs", obs2, expOut(2));
        checkVec("dut8_outputs", obs8, expOut(8));
    endtask

    task automatic applyStimulus(input logic lock, input int cycles);
        pllLocked = lock;
        repeat (cycles) begin
            @(negedge clk);
            checkOutput();
        end
    endtask

    task automatic waitUntilT(input int target);
        int n = 0;
        while (!(mActive && mT >= target) && n < 400) begin
            @(negedge clk);
            checkOutput();
            n++;
        end
        if (n >= 400) begin
            total++;
            bad++;
            $error("[TB] FAIL wait_timeout observed=%0d expected=%0d", mT, target);
        end
    endtask

    task automatic resetPulse();
        rstN = 1'b0;
        @(negedge clk);
        checkOutput();
        rstN = 1'b1;
    endtask

    // Raises lock and returns cycles until cke2 rises (bounded).
    task automatic lockAndMeasure(output int n);
        n = 0;
        pllLocked = 1'b1;
        do begin
            @(negedge clk);
            checkOutput();
            n++;
        end while (!cke2 && n < 20);
    endtask

    task automatic dropAndMeasure(input bit watchDone, output int n);
        n = 0;
        pllLocked = 1'b0;
        do begin
            @(negedge clk);
            checkOutput();
            n++;
        end while ((watchDone ? done2 : cke2) && n < 10);
    endtask

    initial begin
        int n, n2, n8, refs2, refs8;
        rstN      = 1'b0;
        pllLocked = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput();
        end
        checkVec("reset_dut2", obs2, RESET_VEC);
        checkVec("reset_dut8", obs8, RESET_VEC);
        rstN = 1'b1;
        applyStimulus(1'b0, 3);

        $display("[TB] clean power-up sequence");
        lockAndMeasure(n);
        checkInt("cke_latency", n, 2 + LS);
        n = 0;
        while (!(csN2 == 1'b0 && rasN2 == 1'b0 && casN2 == 1'b1 && weN2 == 1'b0) && n < 200) begin
            @(negedge clk);
            checkOutput();
            n++;
        end
        checkInt("precharge_latency", n, PU);
        checkInt("precharge_a10", int'(addr2[10]), 1);
        n = 0; n2 = -1; n8 = -1; refs2 = 0; refs8 = 0;
        while (!(done2 && done8) && n < 300) begin
            @(negedge clk);
            checkOutput();
            n++;
            if ({csN2, rasN2, casN2, weN2} == 4'b0001) refs2++;
            if ({csN8, rasN8, casN8, weN8} == 4'b0001) refs8++;
            if (done2 && n2 < 0) n2 = n;
            if (done8 && n8 < 0) n8 = n;
        end
        checkInt("refresh_count_2", refs2, 2);
        checkInt("refresh_count_8", refs8, 8);
        checkInt("done_latency_2", n2, TRP + 2 * TRFC + TMRD);
        checkInt("done_latency_8", n8, TRP + 8 * TRFC + TMRD);
        applyStimulus(1'b1, 5);

        $display("[TB] lock glitch before stable run");
        resetPulse();
        applyStimulus(1'b0, 3);
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 1);
        lockAndMeasure(n);
        checkInt("glitch_cke_latency", n, 2 + LS);
        waitUntilT(PU + TRP + 8 * TRFC + TMRD + 2);

        $display("[TB] lock loss during refresh wait");
        resetPulse();
        applyStimulus(1'b0, 2);
        pllLocked = 1'b1;
        waitUntilT(PU + TRP + 3);
        dropAndMeasure(1'b0, n);
        checkInt("trfc_drop_latency", n, 3);
        checkInt("trfc_drop_cs_n", int'(csN2), 1);
        applyStimulus(1'b0, 5);
        lockAndMeasure(n);
        checkInt("relock_cke_latency", n, 2 + LS);
        waitUntilT(PU + TRP + 8 * TRFC + TMRD + 2);

        $display("[TB] lock loss in done");
        dropAndMeasure(1'b1, n);
        checkInt("done_drop_latency", n, 3);
        applyStimulus(1'b0, 4);

        $display("[TB] async reset mid power-up");
        pllLocked = 1'b1;
        waitUntilT(50);
        #2 rstN = 1'b0;
        #1;
        checkVec("async_reset_dut2", obs2, RESET_VEC);
        checkVec("async_reset_dut8", obs8, RESET_VEC);
        checkOutput();
        @(negedge clk);
        checkOutput();
        rstN = 1'b1;
        waitUntilT(PU + TRP + 8 * TRFC + TMRD + 2);

        $display("[TB] randomized lock activity");
        for (int i = 0; i < 10; i++) begin
            int hold;
            hold = ($urandom_range(0, 2) == 0) ? int'($urandom_range(110, 180))
                                               : int'($urandom_range(1, 12));
            applyStimulus(logic'($urandom_range(0, 1)), hold);
            if ($urandom_range(0, 4) == 0) begin
                #2 rstN = 1'b0;
                #1 checkOutput();
                @(negedge clk);
                checkOutput();
                rstN = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
